// File: rtl/counter_pkg.sv
// Shared definitions for the counter_91 sequencer: one-hot state encoding
// and the fixed load-to-dn latency of the attached counter_91.
package counter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_LOAD = 4'b0010,
        ST_WAIT = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    // Bit positions inside the one-hot state register
    localparam int ST_IDLE_BIT = 0;
    localparam int ST_LOAD_BIT = 1;
    localparam int ST_DONE_BIT = 3;

    // counter_91 keeps dn low for this many cycles after the cycle following ld
    localparam int CTR_DLY = 91;

endpackage

// File: rtl/counter_sat_dn.sv
// Saturating W-bit up counter with synchronous clear; holds at MAX.
// Clear takes priority over increment.
module counter_sat_dn #(
    parameter int W   = 8,
    parameter int MAX = (1 << W) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] QMAX = W'(MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != QMAX)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/counter_91_seq.sv
// Sequencer for counter_91: issues n ld pulses, each after the previous dn,
// then a one-cycle done; a watchdog aborts with err if dn never arrives.
module counter_91_seq
    import counter_pkg::*;
#(
    parameter int CW  = 8,
    parameter int WW  = 8,
    parameter int TMO = 127
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [CW-1:0] n,
    input  logic          abort,
    input  logic          dn,
    output logic          ld,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cnt
);

    localparam logic [WW-1:0] WD_LAST = WW'(TMO - 1);

    state_t        state;
    logic [CW-1:0] rem;
    logic [WW-1:0] wd_q;
    logic          wd_inc;
    logic          wd_hit;

    // ld and done come straight off state flops, so they are glitch-free
    assign ld   = state[ST_LOAD_BIT];
    assign done = state[ST_DONE_BIT];
    assign busy = !state[ST_IDLE_BIT];

    assign wd_inc = (state == ST_WAIT) && !dn && !abort;
    assign wd_hit = wd_inc && (wd_q == WD_LAST);

    counter_sat_dn #(
        .W   (WW),
        .MAX (TMO)
    ) u_wd (
        .clk (clk),
        .rst (rst),
        .clr (ld),
        .inc (wd_inc),
        .q   (wd_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            rem   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        cnt <= '0;
                        err <= 1'b0;
                        if (n != '0) begin
                            rem   <= n;
                            state <= ST_LOAD;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    state <= abort ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (dn) begin
                        cnt   <= cnt + CW'(1);
                        rem   <= rem - CW'(1);
                        state <= (rem == CW'(1)) ? ST_DONE : ST_LOAD;
                    end else if (wd_hit) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // With counter_91 attached, dn lands exactly CTR_DLY WAIT cycles after ld
    assert property (@(posedge clk) disable iff (rst)
        ((state == ST_WAIT) && dn) |-> (wd_q == WW'(CTR_DLY)));

endmodule

// File: tb/tb_counter_91_seq.sv
// Bench for counter_91_seq with a behavioural counter_91 on ld/dn; event
// cycles relative to the req cycle are queued and matched as they appear.
module tb_counter_91_seq;
    import counter_pkg::*;

    localparam int CW  = 8;
    localparam int WW  = 8;
    localparam int TMO = 127;
    localparam int IV  = CTR_DLY + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [CW-1:0] n = '0;
    logic          abort = 1'b0;
    logic          dn;
    logic          ld, busy, done, err;
    logic [CW-1:0] cnt;
    logic          disc = 1'b0;

    logic [7:0]    ctr;
    logic          armed;
    logic          err_d = 1'b0;

    int cyc   = 0;
    int base  = 0;
    int tests = 0;
    int fails = 0;
    int exp_ld_q[$];
    int exp_done_q[$];
    int exp_err_q[$];

    counter_91_seq #(.CW(CW), .WW(WW), .TMO(TMO)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .n     (n),
        .abort (abort),
        .dn    (dn),
        .ld    (ld),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural counter_91: dn high CTR_DLY+1 cycles after the ld cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr   <= '0;
            armed <= 1'b0;
        end else if (ld) begin
            ctr   <= 8'(CTR_DLY);
            armed <= 1'b1;
        end else if (ctr != '0) begin
            ctr <= ctr - 8'd1;
        end else begin
            armed <= 1'b0;
        end
    end
    assign dn = armed && (ctr == '0) && !disc;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc - base);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ld) begin
                if (exp_ld_q.size() == 0) chk("ld_extra", exp_ld_q.size(), 1);
                else chk("ld_cycle", cyc - base, exp_ld_q.pop_front());
            end
            if (done) begin
                if (exp_done_q.size() == 0) chk("done_extra", exp_done_q.size(), 1);
                else chk("done_cycle", cyc - base, exp_done_q.pop_front());
            end
            if (err && !err_d) begin
                if (exp_err_q.size() == 0) chk("err_extra", exp_err_q.size(), 1);
                else chk("err_cycle", cyc - base, exp_err_q.pop_front());
            end
        end
        err_d = err;
    end

    task automatic start(input int nn);
        @(posedge clk);
        #1;
        req  = 1'b1;
        n    = CW'(nn);
        base = cyc;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int exp_cyc, input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(tag, cyc - base, exp_cyc);
    endtask

    task automatic end_checks(input string tag, input int exp_cnt, input int exp_err);
        chk({tag, "_cnt"}, int'(cnt), exp_cnt);
        chk({tag, "_err"}, int'(err), exp_err);
        chk({tag, "_ld_left"}, exp_ld_q.size(), 0);
        chk({tag, "_done_left"}, exp_done_q.size(), 0);
        chk({tag, "_err_left"}, exp_err_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ld", int'(ld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cnt", int'(cnt), 0);
        rst = 1'b0;

        // n=1
        exp_ld_q.push_back(1);
        exp_done_q.push_back(IV + 1);
        start(1);
        wait_idle("t1_idle", IV + 2, 300);
        end_checks("t1", 1, 0);

        // n=3
        for (int i = 0; i < 3; i++) exp_ld_q.push_back(1 + i * IV);
        exp_done_q.push_back(3 * IV + 1);
        start(3);
        wait_idle("t2_idle", 3 * IV + 2, 600);
        end_checks("t2", 3, 0);

        // n=0
        exp_done_q.push_back(1);
        start(0);
        wait_idle("t3_idle", 2, 20);
        end_checks("t3", 0, 0);

        // n=5 aborted in cycle 100 during the second WAIT
        exp_ld_q.push_back(1);
        exp_ld_q.push_back(1 + IV);
        start(5);
        repeat (99) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t4_busy_101", int'(busy), 0);
        repeat (200) @(posedge clk);
        end_checks("t4", 1, 0);

        // counter disconnected: watchdog fires, then next req clears err
        disc = 1'b1;
        exp_ld_q.push_back(1);
        exp_err_q.push_back(TMO + 2);
        start(1);
        wait_idle("t5_idle", TMO + 2, 400);
        chk("t5_err_set", int'(err), 1);
        chk("t5_cnt_hold", int'(cnt), 0);
        disc = 1'b0;
        exp_done_q.push_back(1);
        start(0);
        chk("t5_err_clr", int'(err), 0);
        wait_idle("t5b_idle", 2, 20);
        end_checks("t5", 0, 0);

        // reset in the second WAIT of n=2, then a clean n=2 run
        exp_ld_q.push_back(1);
        exp_ld_q.push_back(1 + IV);
        exp_done_q.push_back(2 * IV + 1);
        start(2);
        repeat (119) @(posedge clk);
        chk("t6_cnt_pre", int'(cnt), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_ld", int'(ld), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_err", int'(err), 0);
        chk("t6_rst_cnt", int'(cnt), 0);
        exp_ld_q.delete();
        exp_done_q.delete();
        exp_err_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ld_q.push_back(1);
        exp_ld_q.push_back(1 + IV);
        exp_done_q.push_back(2 * IV + 1);
        start(2);
        wait_idle("t6_idle", 2 * IV + 2, 400);
        end_checks("t6", 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
